mcycle_unit: RTL
================

# mcycle_unit

Iterative multi-cycle multiply/divide unit in the Execute stage, driven by the Decode→Execute pipeline register's `StartE`/`MCycleOpE` outputs. It returns `Busy`, which the pipeline uses as the `Mstall` hold for that register, so the register and this unit form a start/stall handshake. Operations are unsigned, WIDTH-bit, with a shift-add multiplier and a restoring divider sharing one shift datapath.

## Interface
- `WIDTH`, default 32: operand and result width.
- `CLK` in 1: rising-edge clock.
- `RESETn` in 1: reset, asynchronous, active-low.
- `Start` in 1: request. Driven from `StartE`; held high by the stalled pipeline register for the whole operation.
- `MCycleOp` in 1: operation select. 0 = multiply, 1 = divide.
- `Operand1` in WIDTH: multiplicand or dividend.
- `Operand2` in WIDTH: multiplier or divisor.
- `Result1` out WIDTH: product low word or quotient.
- `Result2` out WIDTH: product high word or remainder.
- `Busy` out 1: stall request, routed to `Mstall`.

## Operation
- States: IDLE, COMPUTE, DONE.
- **IDLE**
  - `Start`=1 → latch operands and op, clear the iteration count, go to COMPUTE.
  - `Busy` is combinationally 1 in this same cycle, so the pipeline stalls immediately.
- **COMPUTE**
  - One iteration per cycle, WIDTH iterations in total, then go to DONE.
  - Count wraps at WIDTH−1.
- **DONE**
  - `Busy`=0 and results are valid; the pipeline advances at the end of this cycle.
  - Always returns to IDLE. `Start`, still high from the same instruction, is ignored in DONE.
- **Busy** = (IDLE & `Start`) | COMPUTE. Busy is 0 in DONE and whenever `RESETn`=0.
- **Multiply**: 2·WIDTH-bit shift-add. {`Result2`,`Result1`} = `Operand1`·`Operand2`.
- **Divide**: restoring, WIDTH+1-bit partial remainder subtract.
  - Divisor 0 → quotient all-ones, remainder = dividend. This falls out of the algorithm; no special case is needed.
- **Result registers**
  - Updated only on the COMPUTE→DONE transition.
  - Held until the next completion.
- Operand changes after acceptance have no effect.
- `MCycleOp` is sampled only in IDLE.
- **Reset**
  - State IDLE; `Result1`=`Result2`=0; internal registers 0.
  - Reset asserted mid-operation aborts the operation immediately: `Busy` drops asynchronously and results read 0.

## Timing
- Acceptance cycle is A (IDLE with `Start`=1).
- `Busy` is high in cycles A .. A+WIDTH, i.e. WIDTH+1 cycles (33 at default).
- Cycle A+WIDTH+1 is DONE: `Busy`=0 and results are valid.
- Earliest next acceptance is A+WIDTH+2, in IDLE.
- A back-to-back MCycle instruction sees `Start`=1 in that IDLE cycle and starts without a gap.
- `Start`=0 in IDLE → `Busy`=0 and there are no state changes.
- The unit never asserts `Busy` in the DONE cycle. This keeps the pipeline register from holding one extra cycle.

## Configuration
- Macro: `MCYCLE_DIV_EN`.
- Defined: divider datapath compiled in; behaviour as above.
- Undefined:
  - Divider logic removed.
  - A request with `MCycleOp`=1 is not accepted: `Busy` stays 0, the state stays IDLE, and results are unchanged.
  - Multiply is unaffected.

## Structure
- Shared package `mcycle_pkg` holds:
  - State enum `mcycle_state_t` (IDLE, COMPUTE, DONE).
  - Op constants `MCYCLE_OP_MUL`=1'b0 and `MCYCLE_OP_DIV`=1'b1.
- One natural sub-module, `mcycle_datapath`:
  - Contains the shift registers, adder/subtractor and iteration step.
  - Controlled by the FSM in `mcycle_unit` via load/step/op strobes.

## Test plan
- **Multiply 7·6**: `Start`=1, `MCycleOp`=0, operands 7 and 6 → `Busy` high exactly 33 cycles; DONE shows `Result1`=42, `Result2`=0.
- **Multiply max**: 0xFFFFFFFF·0xFFFFFFFF → `Result2`=0xFFFFFFFE, `Result1`=0x00000001.
- **Divide 100/7** → `Result1`=14, `Result2`=2. With `Start` held through DONE, there is no restart and `Busy` is 0 in the cycle after DONE.
- **Divide by zero**: 5/0 → `Result1`=0xFFFFFFFF, `Result2`=5, same latency as a normal divide.
- **Reset mid-operation**: `RESETn` low in COMPUTE iteration 10 → `Busy`=0 and results 0 immediately. A new 3·4 request after release → `Result1`=12.
- **Macro off**: `MCYCLE_DIV_EN` undefined, divide request → `Busy` never asserts and results stay at the previous multiply values. A following multiply 9·9 → 81.

Source files
------------

// File: rtl/mcycle_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mcycle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } mcycle_state_t;

  localparam logic MCYCLE_OP_MUL = 1'b0;
  localparam logic MCYCLE_OP_DIV = 1'b1;

endpackage

// File: rtl/mcycle_datapath.sv
// Shared shift datapath: shift-add multiply and restoring divide on one adder/subtractor.
// The divide path is present only when MCYCLE_DIV_EN is defined.
module mcycle_datapath
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] hi_d_o,
  output logic [WIDTH-1:0] lo_d_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   add_a_s;
  logic [WIDTH:0]   add_b_s;
  logic             cin_s;
  logic [WIDTH+1:0] addsub_s;

`ifdef MCYCLE_DIV_EN
  logic op_q, op_d;
  logic no_borrow_s;
`else
  logic unused_s;
  assign unused_s = ^{op_i, addsub_s[WIDTH+1]};
`endif

  // Operand select for the single adder; divide uses a + ~b + 1 so bit WIDTH+1 is "no borrow".
  always_comb begin
    add_a_s = {1'b0, hi_q};
    add_b_s = lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}};
    cin_s   = 1'b0;
`ifdef MCYCLE_DIV_EN
    if (op_q == MCYCLE_OP_DIV) begin
      add_a_s = {hi_q, lo_q[WIDTH-1]};
      add_b_s = ~{1'b0, b_q};
      cin_s   = 1'b1;
    end else begin
      cin_s   = 1'b0;
    end
`endif
  end

  assign addsub_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(WIDTH+1){1'b0}}, cin_s};

`ifdef MCYCLE_DIV_EN
  assign no_borrow_s = addsub_s[WIDTH+1];
`endif

  // Next-state for the shift registers: load, one iteration, or hold.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    b_d  = b_q;
`ifdef MCYCLE_DIV_EN
    op_d = op_q;
`endif
    if (load_i) begin
      hi_d = {WIDTH{1'b0}};
`ifdef MCYCLE_DIV_EN
      op_d = op_i;
      if (op_i == MCYCLE_OP_DIV) begin
        lo_d = opa_i;
        b_d  = opb_i;
      end else begin
        lo_d = opb_i;
        b_d  = opa_i;
      end
`else
      lo_d = opb_i;
      b_d  = opa_i;
`endif
    end else if (step_i) begin
`ifdef MCYCLE_DIV_EN
      if (op_q == MCYCLE_OP_DIV) begin
        hi_d = no_borrow_s ? addsub_s[WIDTH-1:0] : add_a_s[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], no_borrow_s};
      end else begin
        {hi_d, lo_d} = {addsub_s[WIDTH:0], lo_q[WIDTH-1:1]};
      end
`else
      {hi_d, lo_d} = {addsub_s[WIDTH:0], lo_q[WIDTH-1:1]};
`endif
    end else begin
      hi_d = hi_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= {WIDTH{1'b0}};
      lo_q <= {WIDTH{1'b0}};
      b_q  <= {WIDTH{1'b0}};
`ifdef MCYCLE_DIV_EN
      op_q <= MCYCLE_OP_MUL;
`endif
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
`ifdef MCYCLE_DIV_EN
      op_q <= op_d;
`endif
    end
  end

  assign hi_d_o = hi_d;
  assign lo_d_o = lo_d;

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned multiply/divide with a Start/Busy stall handshake.
// Divide support is compiled in only when MCYCLE_DIV_EN is defined.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  mcycle_state_t    state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] result1_q;
  logic [WIDTH-1:0] result2_q;
  logic             accept_s;
  logic             load_s;
  logic             step_s;
  logic [WIDTH-1:0] dp_hi_d_s;
  logic [WIDTH-1:0] dp_lo_d_s;

`ifdef MCYCLE_DIV_EN
  assign accept_s = Start;
`else
  assign accept_s = Start & (MCycleOp == MCYCLE_OP_MUL);
`endif

  assign load_s = (state_q == IDLE) & accept_s;
  assign step_s = (state_q == COMPUTE);
  // Combinational so the pipeline stalls in the acceptance cycle; gated so reset drops it at once.
  assign Busy   = RESETn & (load_s | step_s);

  mcycle_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk_i  (CLK),
    .rst_ni (RESETn),
    .load_i (load_s),
    .step_i (step_s),
    .op_i   (MCycleOp),
    .opa_i  (Operand1),
    .opb_i  (Operand2),
    .hi_d_o (dp_hi_d_s),
    .lo_d_o (dp_lo_d_s)
  );

  // Control FSM, iteration counter and result capture on the final iteration.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= IDLE;
      count_q   <= {CW{1'b0}};
      result1_q <= {WIDTH{1'b0}};
      result2_q <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q <= COMPUTE;
            count_q <= {CW{1'b0}};
          end else begin
            state_q <= IDLE;
          end
        end
        COMPUTE: begin
          if (count_q == CNT_MAX) begin
            state_q   <= DONE;
            count_q   <= {CW{1'b0}};
            result1_q <= dp_lo_d_s;
            result2_q <= dp_hi_d_s;
          end else begin
            count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Result1 = result1_q;
  assign Result2 = result2_q;

endmodule
